// File: rtl/pwm_pkg.sv
// Shared definitions for the PWM timebase and its neighbours (pwm_gen, register block).
package pwm_pkg;
    localparam int CNT_W_DEF = 16;
    localparam int PSC_W_DEF = 8;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;
endpackage

// File: rtl/pwm_prescaler.sv
// Clock-enable divider: one tick every shadow_prescale+1 enabled clocks.
module pwm_prescaler
    import pwm_pkg::*;
#(
    parameter int PSC_W = PSC_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             clr,
    input  logic [PSC_W-1:0] shadow_prescale,
    output logic             tick
);
    logic [PSC_W-1:0] psc_cnt_reg;

    // >= rather than == so a count held across a disable never overshoots a smaller new prescale.
    assign tick = en && !clr && (psc_cnt_reg >= shadow_prescale);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            psc_cnt_reg <= '0;
        end else if (clr) begin
            psc_cnt_reg <= '0;
        end else if (en) begin
            if (tick) begin
                psc_cnt_reg <= '0;
            end else begin
                psc_cnt_reg <= psc_cnt_reg + PSC_W'(1);
            end
        end
    end
endmodule

// File: rtl/pwm_counter.sv
// PWM timebase: up/down counter with double-buffered period, prescale and direction.
module pwm_counter
    import pwm_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF,
    parameter int PSC_W = PSC_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             count_en,
    input  logic             count_reset,
    input  logic             upnotdown,
    input  logic [CNT_W-1:0] period,
    input  logic [PSC_W-1:0] prescale,
    output logic [CNT_W-1:0] count_val,
    output logic             period_done
);
    logic [CNT_W-1:0] count_reg;
    logic             done_reg;
    logic [CNT_W-1:0] period_sh_reg;
    logic [PSC_W-1:0] prescale_sh_reg;
    logic             dir_sh_reg;
    logic             tick;
    logic [CNT_W-1:0] count_next;
    logic             wrap;

    pwm_prescaler #(
        .PSC_W(PSC_W)
    ) u_prescaler (
        .clk             (clk),
        .rst_n           (rst_n),
        .en              (count_en),
        .clr             (count_reset),
        .shadow_prescale (prescale_sh_reg),
        .tick            (tick)
    );

    // Next count for a tick; out-of-range values (after a period shrink) wrap immediately.
    always_comb begin
        count_next = count_reg;
        wrap       = 1'b0;
        if (dir_sh_reg == DIR_UP) begin
            if (count_reg >= period_sh_reg) begin
                count_next = '0;
                wrap       = 1'b1;
            end else begin
                count_next = count_reg + CNT_W'(1);
            end
        end else begin
            if (count_reg == '0 || count_reg > period_sh_reg) begin
                count_next = period_sh_reg;
                wrap       = 1'b1;
            end else begin
                count_next = count_reg - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_reg       <= '0;
            done_reg        <= 1'b0;
            period_sh_reg   <= '0;
            prescale_sh_reg <= '0;
            dir_sh_reg      <= DIR_UP;
        end else if (count_reset || !count_en) begin
            // Clear keeps count at 0; stop holds it. Both track the inputs into the shadows.
            if (count_reset) begin
                count_reg <= '0;
            end
            done_reg        <= 1'b0;
            period_sh_reg   <= period;
            prescale_sh_reg <= prescale;
            dir_sh_reg      <= upnotdown;
        end else if (tick) begin
            count_reg <= count_next;
            done_reg  <= wrap;
            if (wrap) begin
                period_sh_reg   <= period;
                prescale_sh_reg <= prescale;
                dir_sh_reg      <= upnotdown;
            end
        end else begin
            done_reg <= 1'b0;
        end
    end

    assign count_val   = count_reg;
    assign period_done = done_reg;
endmodule

// File: tb/tb_pwm_counter.sv
// Self-checking bench for pwm_counter: vector table, directed corner cases, random vs. model.
module tb_pwm_counter;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        count_en = 1'b0;
    logic        count_reset = 1'b0;
    logic        upnotdown = 1'b1;
    logic [15:0] period = '0;
    logic [7:0]  prescale = '0;
    logic [15:0] count_val;
    logic        period_done;

    int tests = 0;
    int fails = 0;

    pwm_counter dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .count_en    (count_en),
        .count_reset (count_reset),
        .upnotdown   (upnotdown),
        .period      (period),
        .prescale    (prescale),
        .count_val   (count_val),
        .period_done (period_done)
    );

    always #5 clk = ~clk;

    // Reference model state: what the spec says the block holds after each edge.
    int m_cnt, m_psc, m_p, m_ps, m_dir, m_done;

    task automatic model_reset();
        m_cnt = 0; m_psc = 0; m_p = 0; m_ps = 0; m_dir = 1; m_done = 0;
    endtask

    task automatic model_load();
        m_p = int'(period); m_ps = int'(prescale); m_dir = int'(upnotdown);
    endtask

    task automatic model_step();
        bit w;
        if (!rst_n) begin
            model_reset();
        end else if (count_reset) begin
            m_cnt = 0; m_psc = 0; m_done = 0; model_load();
        end else if (!count_en) begin
            m_done = 0; model_load();
        end else if (m_psc >= m_ps) begin
            m_psc = 0;
            w = 0;
            if (m_dir == 1) begin
                if (m_cnt >= m_p) begin m_cnt = 0; w = 1; end
                else m_cnt = m_cnt + 1;
            end else begin
                if (m_cnt == 0 || m_cnt > m_p) begin m_cnt = m_p; w = 1; end
                else m_cnt = m_cnt - 1;
            end
            m_done = w;
            if (w) model_load();
        end else begin
            m_psc = m_psc + 1;
            m_done = 0;
        end
    endtask

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One clock: model follows the edge, outputs compared at the falling edge.
    task automatic cycle();
        @(posedge clk);
        model_step();
        @(negedge clk);
        check("model_count", int'(count_val), m_cnt);
        check("model_done", int'(period_done), m_done);
    endtask

    task automatic set_in(input logic rst, input logic en, input logic dir,
                          input int per, input int psc);
        count_reset = rst; count_en = en; upnotdown = dir;
        period = 16'(per); prescale = 8'(psc);
    endtask

    typedef struct {
        logic rst; logic en; logic dir; int per; int psc; int exp_cnt; int exp_done;
    } vec_t;
    vec_t vecs[$];

    function automatic vec_t mk(logic rst, logic en, logic dir, int per, int psc, int c, int d);
        vec_t v;
        v.rst = rst; v.en = en; v.dir = dir; v.per = per; v.psc = psc;
        v.exp_cnt = c; v.exp_done = d;
        return v;
    endfunction

    initial begin
        int k, guard, dones;
        int exp_seq[7];
        int exp_dn[7];

        model_reset();
        cycle();
        check("reset_count", int'(count_val), 0);
        check("reset_done", int'(period_done), 0);
        cycle();
        @(negedge clk);
        rst_n = 1'b1;

        // Up P=4, then down P=5 (count_reset loads the shadows first).
        vecs.push_back(mk(1, 1, 1, 4, 0, 0, 0));
        vecs.push_back(mk(0, 1, 1, 4, 0, 1, 0));
        vecs.push_back(mk(0, 1, 1, 4, 0, 2, 0));
        vecs.push_back(mk(0, 1, 1, 4, 0, 3, 0));
        vecs.push_back(mk(0, 1, 1, 4, 0, 4, 0));
        vecs.push_back(mk(0, 1, 1, 4, 0, 0, 1));
        vecs.push_back(mk(0, 1, 1, 4, 0, 1, 0));
        vecs.push_back(mk(1, 1, 0, 5, 0, 0, 0));
        vecs.push_back(mk(0, 1, 0, 5, 0, 5, 1));
        vecs.push_back(mk(0, 1, 0, 5, 0, 4, 0));
        vecs.push_back(mk(0, 1, 0, 5, 0, 3, 0));
        vecs.push_back(mk(0, 1, 0, 5, 0, 2, 0));
        vecs.push_back(mk(0, 1, 0, 5, 0, 1, 0));
        vecs.push_back(mk(0, 1, 0, 5, 0, 0, 0));
        vecs.push_back(mk(0, 1, 0, 5, 0, 5, 1));
        // P=0 up: every tick is a wrap
        vecs.push_back(mk(1, 1, 1, 0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 1, 0, 0, 0, 1));
        vecs.push_back(mk(0, 1, 1, 0, 0, 0, 1));
        foreach (vecs[i]) begin
            set_in(vecs[i].rst, vecs[i].en, vecs[i].dir, vecs[i].per, vecs[i].psc);
            cycle();
            check($sformatf("vec%0d_count", i), int'(count_val), vecs[i].exp_cnt);
            check($sformatf("vec%0d_done", i), int'(period_done), vecs[i].exp_done);
            $display("[TB] vec %0d: count_val=%0d period_done=%0d", i, count_val, period_done);
        end

        // Prescale=2, P=3: each value held 3 clocks, wrap every 12.
        set_in(1, 1, 1, 3, 2);
        cycle();
        count_reset = 1'b0;
        dones = 0;
        for (int j = 1; j <= 24; j++) begin
            cycle();
            dones += int'(period_done);
            check("psc_count", int'(count_val), (j / 3) % 4);
            check("psc_done", int'(period_done), (j % 12 == 0) ? 1 : 0);
        end
        check("psc_wraps", dones, 2);
        $display("[TB] prescale run: %0d wraps in 24 clocks", dones);

        // Period 8 -> 3 written at count 6: new period only after the wrap.
        set_in(1, 1, 1, 8, 0);
        cycle();
        count_reset = 1'b0;
        guard = 0;
        while (count_val != 16'd6 && guard < 50) begin cycle(); guard++; end
        check("reach6_timeout", (guard < 50) ? 1 : 0, 1);
        period = 16'd3;
        exp_seq = '{7, 8, 0, 1, 2, 3, 0};
        exp_dn  = '{0, 0, 1, 0, 0, 0, 1};
        for (int j = 0; j < 7; j++) begin
            cycle();
            check("reload_count", int'(count_val), exp_seq[j]);
            check("reload_done", int'(period_done), exp_dn[j]);
        end
        $display("[TB] period reload sequence done, count_val=%0d", count_val);

        // count_reset at 5, then 4-clock disable.
        set_in(1, 1, 1, 9, 0);
        cycle();
        count_reset = 1'b0;
        guard = 0;
        while (count_val != 16'd5 && guard < 50) begin cycle(); guard++; end
        check("reach5_timeout", (guard < 50) ? 1 : 0, 1);
        count_reset = 1'b1;
        cycle();
        check("clr_count", int'(count_val), 0);
        check("clr_done", int'(period_done), 0);
        count_reset = 1'b0;
        for (int j = 0; j < 3; j++) cycle();
        count_en = 1'b0;
        for (int j = 0; j < 4; j++) begin
            cycle();
            check("hold_count", int'(count_val), 3);
            check("hold_done", int'(period_done), 0);
        end
        count_en = 1'b1;
        cycle();
        check("resume_count", int'(count_val), 4);
        $display("[TB] clear/disable sequence done, count_val=%0d", count_val);

        // Asynchronous reset between edges.
        cycle();
        #2 rst_n = 1'b0;
        #1;
        check("async_count", int'(count_val), 0);
        check("async_done", int'(period_done), 0);
        cycle();
        #2 rst_n = 1'b1;
        set_in(0, 1, 1, 6, 1);
        for (int j = 0; j < 20; j++) cycle();
        $display("[TB] async reset recovery done, count_val=%0d", count_val);

        // Random traffic against the model.
        for (int j = 0; j < 3000; j++) begin
            count_reset = ($urandom_range(0, 99) < 2);
            count_en    = ($urandom_range(0, 99) >= 10);
            if ($urandom_range(0, 9) == 0) upnotdown = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 9) == 0) period = 16'($urandom_range(0, 10));
            if ($urandom_range(0, 9) == 0) prescale = 8'($urandom_range(0, 3));
            cycle();
        end
        $display("[TB] random run done, count_val=%0d", count_val);

        k = tests;
        $display("[TB] %0d tests run, %0d failed", k, fails);
        $finish;
    end
endmodule
